// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch FSM states
//   fetch_pkt_t   : {pc, instr} pair carried into the IF/ID register
//   opcode_of()   : extracts the decode opcode field from an instruction word
package fetch_pkg;

    localparam int PC_W       = 64;
    localparam int INSTR_W    = 32;
    localparam int OPCODE_W   = 11;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 21;

    localparam logic [PC_W-1:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // issue request
        S_WAIT  = 2'd1,  // await response
        S_HOLD  = 2'd2,  // response buffered while decode stalls
        S_DRAIN = 2'd3   // swallow a response that a redirect made stale
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_pkt_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg -- IF/ID pipeline register.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture load_pkt and mark valid
//   hold       : keep current contents (decode stall)
//   clear      : flush; drop the valid bit
//   load_pkt   : {pc, instr} to capture
//   id_valid   : register holds a real instruction
//   id_pkt     : registered {pc, instr}
// Priority: reset > clear > load > hold > bubble. With none of
// load/hold/clear asserted the entry becomes a bubble (valid=0) but the
// data fields are left untouched; only id_valid qualifies them.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       hold,
    input  logic       clear,
    input  fetch_pkt_t load_pkt,
    output logic       id_valid,
    output fetch_pkt_t id_pkt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_pkt   <= '0;
        end else if (clear) begin
            id_valid <= 1'b0;
        end else if (load) begin
            id_valid <= 1'b1;
            id_pkt   <= load_pkt;
        end else if (!hold) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch -- single-outstanding-request fetch stage.
//   RESET_PC    : PC loaded on reset
//   clk, reset  : clock, synchronous active-high reset
//   imem_req    : one-cycle read request (only in S_REQ, never in reset)
//   imem_addr   : request address, always the current PC
//   imem_valid  : read response valid (1+ cycles after imem_req)
//   imem_rdata  : read response instruction word
//   stall       : decode hazard; freezes IF/ID
//   redirect    : taken branch/jump; flush and restart at redirect_pc
//   redirect_pc : restart address, low two bits forced to zero
//   id_valid/id_pc/id_instr/id_opcode : IF/ID register contents
// The PC only advances when an instruction is handed to IF/ID, so
// imem_addr keeps pointing at the in-flight fetch until it completes.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_valid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                id_valid,
    output logic [PC_W-1:0]     id_pc,
    output logic [INSTR_W-1:0]  id_instr,
    output logic [OPCODE_W-1:0] id_opcode
);

    fetch_state_e       state, state_nxt;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] hold_buf;
    logic               id_load, id_hold, id_clear, capture;
    fetch_pkt_t         load_pkt, id_pkt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_REQ;
        else       state <= state_nxt;
    end

    // Next state. A redirect discards whatever is in flight; if the stale
    // response has not shown up yet we must wait for it in S_DRAIN so it
    // is not mistaken for the redirect target's data.
    always_comb begin
        state_nxt = state;
        if (redirect) begin
            case (state)
                S_REQ:   state_nxt = S_DRAIN;
                S_HOLD:  state_nxt = S_REQ;
                default: state_nxt = imem_valid ? S_REQ : S_DRAIN;
            endcase
        end else begin
            case (state)
                S_REQ:   state_nxt = S_WAIT;
                S_WAIT:  if (imem_valid) state_nxt = stall ? S_HOLD : S_REQ;
                S_HOLD:  if (!stall) state_nxt = S_REQ;
                S_DRAIN: if (imem_valid) state_nxt = S_REQ;
                default: state_nxt = S_REQ;
            endcase
        end
    end

    // Outputs and datapath controls
    always_comb begin
        imem_req = 1'b0;
        id_load  = 1'b0;
        id_hold  = 1'b0;
        id_clear = 1'b0;
        capture  = 1'b0;
        if (!reset && state == S_REQ) imem_req = 1'b1;
        if (redirect) begin
            id_clear = 1'b1;
        end else begin
            id_hold = stall;
            case (state)
                S_WAIT: if (imem_valid) begin
                    if (stall) capture = 1'b1;
                    else       id_load = 1'b1;
                end
                S_HOLD: if (!stall) id_load = 1'b1;
                default: ;
            endcase
        end
    end

    // PC and one-entry hold buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            hold_buf <= '0;
        end else if (redirect) begin
            pc       <= redirect_pc & ~64'h3;
            hold_buf <= '0;
        end else begin
            if (id_load) pc <= pc + PC_STEP;  // wraps modulo 2^64
            if (capture) hold_buf <= imem_rdata;
        end
    end

    assign imem_addr      = pc;
    assign load_pkt.pc    = pc;
    assign load_pkt.instr = (state == S_HOLD) ? hold_buf : imem_rdata;

    if_id_reg u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load     (id_load),
        .hold     (id_hold),
        .clear    (id_clear),
        .load_pkt (load_pkt),
        .id_valid (id_valid),
        .id_pkt   (id_pkt)
    );

    assign id_pc     = id_pkt.pc;
    assign id_instr  = id_pkt.instr;
    assign id_opcode = opcode_of(id_pkt.instr);

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: default RESET_PC
    logic        reset = 1'b1, stall = 1'b0, redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req, imem_valid = 1'b0, id_valid;
    logic [63:0] imem_addr, id_pc;
    logic [31:0] imem_rdata = '0, id_instr;
    logic [10:0] id_opcode;

    // DUT 2: RESET_PC at the top of the address space
    logic        reset2 = 1'b1, stall2 = 1'b0, redirect2 = 1'b0;
    logic [63:0] redirect_pc2 = '0;
    logic        req2, valid2 = 1'b0, id_valid2;
    logic [63:0] addr2, id_pc2;
    logic [31:0] rdata2 = '0, id_instr2;
    logic [10:0] id_opcode2;

    int n_cmp = 0, n_bad = 0;
    int mem_lat = 1;
    logic        p1 = 1'b0;
    logic [63:0] a1 = '0;

    localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    instruction_fetch dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
        .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode)
    );

    instruction_fetch #(.RESET_PC(TOP_PC)) dut2 (
        .clk(clk), .reset(reset2), .imem_req(req2), .imem_addr(addr2),
        .imem_valid(valid2), .imem_rdata(rdata2), .stall(stall2),
        .redirect(redirect2), .redirect_pc(redirect_pc2), .id_valid(id_valid2),
        .id_pc(id_pc2), .id_instr(id_instr2), .id_opcode(id_opcode2)
    );

    // Memory for DUT 1: latency 1 or 2, returns 32'hF8400000 + address
    always @(posedge clk) begin
        if (reset) begin
            p1         <= 1'b0;
            imem_valid <= 1'b0;
        end else begin
            p1 <= imem_req;
            a1 <= imem_addr;
            if (mem_lat == 1) begin
                imem_valid <= imem_req;
                imem_rdata <= 32'hF840_0000 + imem_addr[31:0];
            end else begin
                imem_valid <= p1;
                imem_rdata <= 32'hF840_0000 + a1[31:0];
            end
        end
    end

    // Memory for DUT 2: latency 1
    always @(posedge clk) begin
        if (reset2) valid2 <= 1'b0;
        else begin
            valid2 <= req2;
            rdata2 <= 32'hF840_0000 + addr2[31:0];
        end
    end

    localparam logic [0:6]  FR_REQ = 7'b1010101;
    localparam logic [0:6]  FR_VLD = 7'b0010101;
    localparam logic [63:0] FR_ADDR [7] = '{64'h0, 64'h0, 64'h4, 64'h4, 64'h8, 64'h8, 64'hC};
    localparam logic [63:0] FR_PC   [7] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h4, 64'h4, 64'h8};

    task test_reset;
        @(posedge clk); #1;
        @(posedge clk); #1;   // t=16, two reset edges seen
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== 64'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        n_cmp++; if (id_pc !== 64'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", id_pc); end
        n_cmp++; if (id_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", id_instr); end
        n_cmp++; if (dut.state !== S_REQ) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, S_REQ); end
        reset = 1'b0;
    endtask

    task test_free_run;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_cmp++; if (imem_req !== FR_REQ[i]) begin n_bad++; $display("FAIL fr_req[%0d]: got %b want %b", i, imem_req, FR_REQ[i]); end
            n_cmp++; if (imem_addr !== FR_ADDR[i]) begin n_bad++; $display("FAIL fr_addr[%0d]: got %h want %h", i, imem_addr, FR_ADDR[i]); end
            n_cmp++; if (id_valid !== FR_VLD[i]) begin n_bad++; $display("FAIL fr_valid[%0d]: got %b want %b", i, id_valid, FR_VLD[i]); end
            if (FR_VLD[i]) begin
                n_cmp++; if (id_pc !== FR_PC[i]) begin n_bad++; $display("FAIL fr_pc[%0d]: got %h want %h", i, id_pc, FR_PC[i]); end
                n_cmp++; if (id_instr !== (32'hF840_0000 | FR_PC[i][31:0])) begin n_bad++; $display("FAIL fr_instr[%0d]: got %h", i, id_instr); end
                n_cmp++; if (id_opcode !== 11'h7C2) begin n_bad++; $display("FAIL fr_opcode[%0d]: got %h want 7c2", i, id_opcode); end
            end
        end
    endtask

    task test_stall;
        stall = 1'b1;   // t=80, held across three rising edges
        @(negedge clk);
        n_cmp++; if (dut.state !== S_WAIT) begin n_bad++; $display("FAIL st_state0: got %0d want %0d", dut.state, S_WAIT); end
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'h8) begin n_bad++; $display("FAIL st_hold0: got v=%b pc=%h want v=1 pc=8", id_valid, id_pc); end
        @(negedge clk);
        n_cmp++; if (dut.state !== S_HOLD) begin n_bad++; $display("FAIL st_state1: got %0d want %0d", dut.state, S_HOLD); end
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'h8 || id_instr !== 32'hF840_0008) begin n_bad++; $display("FAIL st_hold1: got v=%b pc=%h i=%h", id_valid, id_pc, id_instr); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL st_req1: got %b want 0", imem_req); end
        @(negedge clk);
        n_cmp++; if (dut.state !== S_HOLD) begin n_bad++; $display("FAIL st_state2: got %0d want %0d", dut.state, S_HOLD); end
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'h8) begin n_bad++; $display("FAIL st_hold2: got v=%b pc=%h want v=1 pc=8", id_valid, id_pc); end
        stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'hC || id_instr !== 32'hF840_000C) begin n_bad++; $display("FAIL st_release: got v=%b pc=%h i=%h want 1 c f840000c", id_valid, id_pc, id_instr); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h10) begin n_bad++; $display("FAIL st_nextreq: got r=%b a=%h want 1 10", imem_req, imem_addr); end
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL st_bubble: got %b want 0", id_valid); end
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'h10 || id_instr !== 32'hF840_0010) begin n_bad++; $display("FAIL st_after: got v=%b pc=%h i=%h want 1 10 f8400010", id_valid, id_pc, id_instr); end
    endtask

    task test_redirect_wait;
        mem_lat = 2;    // t=140
        @(negedge clk);
        n_cmp++; if (dut.state !== S_WAIT || imem_addr !== 64'h14) begin n_bad++; $display("FAIL rw_pre: got s=%0d a=%h want wait 14", dut.state, imem_addr); end
        redirect = 1'b1; redirect_pc = 64'h103;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++; if (dut.state !== S_DRAIN) begin n_bad++; $display("FAIL rw_state: got %0d want %0d", dut.state, S_DRAIN); end
        n_cmp++; if (imem_addr !== 64'h100) begin n_bad++; $display("FAIL rw_addr: got %h want 100", imem_addr); end
        n_cmp++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin n_bad++; $display("FAIL rw_quiet: got v=%b r=%b want 0 0", id_valid, imem_req); end
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin n_bad++; $display("FAIL rw_req: got r=%b a=%h want 1 100", imem_req, imem_addr); end
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rw_stale: got %b want 0", id_valid); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rw_wait[%0d]: got %b want 0", i, id_valid); end
        end
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'h100 || id_instr !== 32'hF840_0100) begin n_bad++; $display("FAIL rw_load: got v=%b pc=%h i=%h want 1 100 f8400100", id_valid, id_pc, id_instr); end
    endtask

    task test_redirect_hold;
        mem_lat = 1; stall = 1'b1;   // t=200
        @(negedge clk);
        n_cmp++; if (dut.state !== S_WAIT || id_valid !== 1'b1) begin n_bad++; $display("FAIL rh_pre0: got s=%0d v=%b", dut.state, id_valid); end
        @(negedge clk);
        n_cmp++; if (dut.state !== S_HOLD || id_pc !== 64'h100) begin n_bad++; $display("FAIL rh_pre1: got s=%0d pc=%h want hold 100", dut.state, id_pc); end
        redirect = 1'b1; redirect_pc = 64'h2002;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rh_flush: got %b want 0", id_valid); end
        n_cmp++; if (dut.hold_buf !== 32'h0) begin n_bad++; $display("FAIL rh_buf: got %h want 0", dut.hold_buf); end
        n_cmp++; if (dut.state !== S_REQ || imem_req !== 1'b1 || imem_addr !== 64'h2000) begin n_bad++; $display("FAIL rh_req: got s=%0d r=%b a=%h want req 1 2000", dut.state, imem_req, imem_addr); end
        redirect = 1'b0; stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rh_bubble: got %b want 0", id_valid); end
        @(negedge clk);
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 64'h2000 || id_instr !== 32'hF840_2000) begin n_bad++; $display("FAIL rh_load: got v=%b pc=%h i=%h want 1 2000 f8402000", id_valid, id_pc, id_instr); end
        n_cmp++; if (id_opcode !== 11'h7C2) begin n_bad++; $display("FAIL rh_opcode: got %h want 7c2", id_opcode); end
    endtask

    task test_wrap;
        // t=250, DUT 2 has been in reset since time 0
        n_cmp++; if (addr2 !== TOP_PC || req2 !== 1'b0 || id_valid2 !== 1'b0) begin n_bad++; $display("FAIL wr_reset: got a=%h r=%b v=%b", addr2, req2, id_valid2); end
        reset2 = 1'b0;
        #1;
        n_cmp++; if (req2 !== 1'b1 || addr2 !== TOP_PC) begin n_bad++; $display("FAIL wr_first: got r=%b a=%h want 1 fffffffffffffffc", req2, addr2); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (addr2 !== 64'h0 || req2 !== 1'b1) begin n_bad++; $display("FAIL wr_addr: got a=%h r=%b want 0 1", addr2, req2); end
        n_cmp++; if (id_valid2 !== 1'b1 || id_pc2 !== TOP_PC || id_instr2 !== 32'hF83F_FFFC) begin n_bad++; $display("FAIL wr_load: got v=%b pc=%h i=%h", id_valid2, id_pc2, id_instr2); end
        n_cmp++; if (id_opcode2 !== 11'h7C1) begin n_bad++; $display("FAIL wr_opcode: got %h want 7c1", id_opcode2); end
        @(negedge clk);
        n_cmp++; if (dut2.state !== S_WAIT) begin n_bad++; $display("FAIL wr_wait: got %0d want %0d", dut2.state, S_WAIT); end
        reset2 = 1'b1;
        @(negedge clk);
        n_cmp++; if (addr2 !== TOP_PC || id_valid2 !== 1'b0 || req2 !== 1'b0) begin n_bad++; $display("FAIL wr_rereset: got a=%h v=%b r=%b", addr2, id_valid2, req2); end
        n_cmp++; if (id_pc2 !== 64'h0 || id_instr2 !== 32'h0 || dut2.state !== S_REQ) begin n_bad++; $display("FAIL wr_clear: got pc=%h i=%h s=%0d", id_pc2, id_instr2, dut2.state); end
    endtask

    initial begin
        test_reset;
        test_free_run;
        test_stall;
        test_redirect_wait;
        test_redirect_hold;
        test_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
